fft_bitrev_reorder: RTL and testbench

Output reorder buffer for the radix-2^2 SDF FFT pipeline. It consumes the bit-reversed-order sample stream produced by the sdf FFT stages and re-emits each N-point frame in natural order. It sits directly after the last FFT stage or twiddle multiplier and uses the same enable-framed streaming interface on both sides. Storage is a ping-pong double buffer, so back-to-back frames stream with no gaps.

---
 rtl/fft_bitrev_reorder_if.sv | 26 ++
 rtl/fft_bitrev_reorder.sv | 126 ++++++++++++
 tb/tb_fft_bitrev_reorder.sv | 390 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_bitrev_reorder_if.sv
// Streaming port bundle for the FFT bit-reversal reorder buffer.
// The producer drives the enable-framed input stream, and the reorder block drives the natural-order output stream.
interface fft_bitrev_reorder_if #(
  parameter int WIDTH = 8
);
  // Handshake: no back-pressure. A sample transfers on every rising edge where
  // its enable is high, and one frame is N consecutive enable-high cycles.
  logic             enable_in;
  logic [WIDTH-1:0] in_re;
  logic [WIDTH-1:0] in_im;
  logic             enable_out;
  logic [WIDTH-1:0] out_re;
  logic [WIDTH-1:0] out_im;
  logic             frame_drop;
  logic             dbg_reading;

  modport master (
    output enable_in, in_re, in_im,
    input  enable_out, out_re, out_im, frame_drop, dbg_reading
  );

  modport slave (
    input  enable_in, in_re, in_im,
    output enable_out, out_re, out_im, frame_drop, dbg_reading
  );
endinterface

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer that turns bit-reversed SDF FFT frames into natural order.
// Writes are scattered to bit-reversed addresses, and reads walk the addresses linearly.
module fft_bitrev_reorder #(
  parameter int N     = 64,
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fft_bitrev_reorder_if.slave  bus
);
  localparam int              LOGN = $clog2(N);
  localparam logic [LOGN-1:0] LAST = LOGN'(N - 1);

  typedef enum logic {IDLE = 1'b0, READ = 1'b1} rd_state_t;

  function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] a);
    logic [LOGN-1:0] r;
    for (int i = 0; i < LOGN; i++) r[i] = a[LOGN-1-i];
    return r;
  endfunction

  logic [2*WIDTH-1:0] mem [0:2*N-1];

  logic [LOGN-1:0] wr_cnt;
  logic            wr_bank;
  logic [LOGN-1:0] rd_cnt, rd_cnt_nxt;
  logic            rd_bank, rd_bank_nxt;
  logic            other_bank;
  logic [1:0]      full, full_set, full_clr;
  rd_state_t       state, state_nxt;
  logic            rd_issue;
  logic            wr_done, drop;

  logic             enable_out_q, frame_drop_q;
  logic [WIDTH-1:0] out_re_q, out_im_q;

  assign wr_done    = bus.enable_in && (wr_cnt == LAST);
  assign drop       = !bus.enable_in && (wr_cnt != '0);
  assign full_set   = wr_done ? (wr_bank ? 2'b10 : 2'b01) : 2'b00;
  assign other_bank = ~rd_bank;

  // The write counter wraps to 0 on its own because N is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt  <= '0;
      wr_bank <= 1'b0;
      full    <= 2'b00;
    end else begin
      if (bus.enable_in) begin
        wr_cnt <= wr_cnt + 1'b1;
        if (wr_done) wr_bank <= ~wr_bank;
      end else if (drop) begin
        wr_cnt <= '0;
      end
      full <= (full & ~full_clr) | full_set;
    end
  end

  always_ff @(posedge clk) begin
    if (bus.enable_in) mem[{wr_bank, bitrev(wr_cnt)}] <= {bus.in_re, bus.in_im};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rd_cnt  <= '0;
      rd_bank <= 1'b0;
    end else begin
      state   <= state_nxt;
      rd_cnt  <= rd_cnt_nxt;
      rd_bank <= rd_bank_nxt;
    end
  end

  // A frame completing on the same edge as the last read keeps the stream gapless.
  always_comb begin
    state_nxt   = state;
    rd_cnt_nxt  = rd_cnt;
    rd_bank_nxt = rd_bank;
    rd_issue    = 1'b0;
    full_clr    = 2'b00;
    case (state)
      IDLE: begin
        if (full[rd_bank]) begin
          state_nxt  = READ;
          rd_cnt_nxt = '0;
        end
      end
      READ: begin
        rd_issue   = 1'b1;
        rd_cnt_nxt = rd_cnt + 1'b1;
        if (rd_cnt == LAST) begin
          full_clr[rd_bank] = 1'b1;
          rd_bank_nxt       = other_bank;
          rd_cnt_nxt        = '0;
          if (!(full[other_bank] || full_set[other_bank])) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable_out_q <= 1'b0;
      frame_drop_q <= 1'b0;
      out_re_q     <= '0;
      out_im_q     <= '0;
    end else begin
      enable_out_q <= rd_issue;
      frame_drop_q <= drop;
      if (rd_issue) {out_re_q, out_im_q} <= mem[{rd_bank, rd_cnt}];
    end
  end

  assign bus.enable_out  = enable_out_q;
  assign bus.frame_drop  = frame_drop_q;
  assign bus.out_re      = out_re_q;
  assign bus.out_im      = out_im_q;
  assign bus.dbg_reading = (state == READ);

  // Completing a frame into a bank that still holds an unread frame means the input outran the reader.
  a_no_overrun: assert property (@(posedge clk) disable iff (!rst_n)
    !(wr_done && full[wr_bank]));

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Self-checking bench for fft_bitrev_reorder: an N=8 instance for the directed scenarios
// and an N=64/WIDTH=16 instance for a long random back-to-back run.
module tb_fft_bitrev_reorder;
  localparam int N8 = 8, W8 = 8, N64 = 64, W64 = 16, L_MAX = 256;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fft_bitrev_reorder_if #(.WIDTH(W8))  bus8();
  fft_bitrev_reorder_if #(.WIDTH(W64)) bus64();

  fft_bitrev_reorder #(.N(N8),  .WIDTH(W8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
  fft_bitrev_reorder #(.N(N64), .WIDTH(W64)) dut64 (.clk(clk), .rst_n(rst_n), .bus(bus64));

  logic          sch_en  [L_MAX];
  logic [W8-1:0] sch_re  [L_MAX];
  logic [W8-1:0] sch_im  [L_MAX];
  int            sch_len;
  logic          obs_en  [L_MAX];
  logic          obs_drop[L_MAX];
  logic [W8-1:0] obs_re  [L_MAX];
  logic [W8-1:0] obs_im  [L_MAX];
  logic          exp_en  [L_MAX];
  logic          exp_drop[L_MAX];
  logic [W8-1:0] exp_re  [L_MAX];
  logic [W8-1:0] exp_im  [L_MAX];

  function automatic int rev_bits(input int k, input int bits);
    int r = 0;
    for (int b = 0; b < bits; b++) r = r * 2 + ((k >> b) & 1);
    return r;
  endfunction

  task automatic clear_sched();
    for (int i = 0; i < L_MAX; i++) begin
      sch_en[i] = 1'b0; sch_re[i] = '0; sch_im[i] = '0;
    end
    sch_len = 0;
  endtask

  task automatic add_idle(input int n);
    for (int i = 0; i < n; i++) begin
      sch_en[sch_len] = 1'b0; sch_len++;
    end
  endtask

  // Frame whose real parts come out in natural order as base+0 .. base+7.
  task automatic add_frame(input int base, input int count);
    for (int k = 0; k < count; k++) begin
      sch_en[sch_len] = 1'b1;
      sch_re[sch_len] = W8'(base + rev_bits(k, 3));
      sch_im[sch_len] = W8'($urandom_range(0, 255));
      sch_len++;
    end
  endtask

  // Reference: every complete run of N samples re-emerges in natural order N+1 cycles after
  // its first sample, and a run cut short raises frame_drop when the low enable is sampled.
  task automatic build_exp8();
    int cnt = 0;
    int start = 0;
    logic [W8-1:0] fr_re [N8];
    logic [W8-1:0] fr_im [N8];
    for (int i = 0; i < L_MAX; i++) begin
      exp_en[i] = 1'b0; exp_drop[i] = 1'b0; exp_re[i] = '0; exp_im[i] = '0;
    end
    for (int c = 0; c < sch_len; c++) begin
      if (sch_en[c]) begin
        if (cnt == 0) start = c;
        fr_re[cnt] = sch_re[c];
        fr_im[cnt] = sch_im[c];
        cnt++;
        if (cnt == N8) begin
          for (int j = 0; j < N8; j++) begin
            if (start + N8 + 1 + j < L_MAX) begin
              exp_en[start + N8 + 1 + j] = 1'b1;
              exp_re[start + N8 + 1 + j] = fr_re[rev_bits(j, 3)];
              exp_im[start + N8 + 1 + j] = fr_im[rev_bits(j, 3)];
            end
          end
          cnt = 0;
        end
      end else if (cnt != 0) begin
        exp_drop[c] = 1'b1;
        cnt = 0;
      end
    end
  endtask

  task automatic run8();
    for (int c = 0; c < sch_len; c++) begin
      @(negedge clk);
      bus8.enable_in = sch_en[c];
      bus8.in_re     = sch_re[c];
      bus8.in_im     = sch_im[c];
      @(posedge clk);
      #1;
      obs_en[c]   = bus8.enable_out;
      obs_drop[c] = bus8.frame_drop;
      obs_re[c]   = bus8.out_re;
      obs_im[c]   = bus8.out_im;
    end
    @(negedge clk);
    bus8.enable_in = 1'b0;
  endtask

  task automatic test_reset();
    bus8.enable_in = 1'b0; bus8.in_re = '0; bus8.in_im = '0;
    bus64.enable_in = 1'b0; bus64.in_re = '0; bus64.in_im = '0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus8.enable_out, bus8.frame_drop, bus8.out_re, bus8.out_im} !== '0) begin
      errors++;
      $display("FAIL reset_n8: en=%b drop=%b re=%h im=%h, required all 0",
               bus8.enable_out, bus8.frame_drop, bus8.out_re, bus8.out_im);
    end
    checks++;
    if ({bus64.enable_out, bus64.frame_drop, bus64.out_re, bus64.out_im} !== '0) begin
      errors++;
      $display("FAIL reset_n64: en=%b drop=%b re=%h im=%h, required all 0",
               bus64.enable_out, bus64.frame_drop, bus64.out_re, bus64.out_im);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus8.enable_out, bus8.frame_drop, bus64.enable_out, bus64.frame_drop} !== 4'b0) begin
      errors++;
      $display("FAIL idle_after_reset: en8=%b drop8=%b en64=%b drop64=%b, required 0",
               bus8.enable_out, bus8.frame_drop, bus64.enable_out, bus64.frame_drop);
    end
  endtask

  task automatic test_single_frame();
    int high = 0;
    int first = -1;
    clear_sched();
    for (int k = 0; k < N8; k++) begin
      sch_en[sch_len] = 1'b1;
      sch_re[sch_len] = W8'(rev_bits(k, 3));
      sch_im[sch_len] = W8'(8'hF0 | k);
      sch_len++;
    end
    add_idle(N8 + 6);
    build_exp8();
    run8();
    for (int c = 0; c < sch_len; c++) begin
      checks++;
      if (obs_en[c] !== exp_en[c] || obs_drop[c] !== exp_drop[c]) begin
        errors++;
        $display("FAIL single_ctrl c=%0d: en=%b drop=%b, required en=%b drop=%b",
                 c, obs_en[c], obs_drop[c], exp_en[c], exp_drop[c]);
      end
      if (exp_en[c]) begin
        checks++;
        if (obs_re[c] !== exp_re[c] || obs_im[c] !== exp_im[c]) begin
          errors++;
          $display("FAIL single_data c=%0d: re=%h im=%h, required re=%h im=%h",
                   c, obs_re[c], obs_im[c], exp_re[c], exp_im[c]);
        end
      end
      if (obs_en[c] === 1'b1) begin
        high++;
        if (first < 0) first = c;
      end
    end
    checks++;
    if (high != 8 || first != 9) begin
      errors++;
      $display("FAIL single_window: high=%0d first=%0d, required 8 and 9", high, first);
    end
    for (int j = 0; j < N8; j++) begin
      checks++;
      if (obs_re[9 + j] !== W8'(j) || obs_im[9 + j] !== W8'(8'hF0 | rev_bits(j, 3))) begin
        errors++;
        $display("FAIL single_order j=%0d: re=%h im=%h, required re=%h im=%h",
                 j, obs_re[9 + j], obs_im[9 + j], j, 8'hF0 | rev_bits(j, 3));
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_sched();
    for (int f = 0; f < 4; f++) add_frame(8 * f, N8);
    add_idle(N8 + 4);
    build_exp8();
    run8();
    for (int c = 0; c < sch_len; c++) begin
      checks++;
      if (obs_en[c] !== exp_en[c] || obs_drop[c] !== exp_drop[c]) begin
        errors++;
        $display("FAIL b2b_ctrl c=%0d: en=%b drop=%b, required en=%b drop=%b",
                 c, obs_en[c], obs_drop[c], exp_en[c], exp_drop[c]);
      end
      if (exp_en[c]) begin
        checks++;
        if (obs_re[c] !== exp_re[c] || obs_im[c] !== exp_im[c]) begin
          errors++;
          $display("FAIL b2b_data c=%0d: re=%h im=%h, required re=%h im=%h",
                   c, obs_re[c], obs_im[c], exp_re[c], exp_im[c]);
        end
      end
    end
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (obs_en[9 + i] !== 1'b1 || obs_re[9 + i] !== W8'(i)) begin
        errors++;
        $display("FAIL b2b_contig i=%0d: en=%b re=%h, required en=1 re=%h",
                 i, obs_en[9 + i], obs_re[9 + i], i);
      end
    end
  endtask

  task automatic test_partial();
    int drops = 0;
    clear_sched();
    add_frame(8'h40, 5);
    add_idle(3);
    add_frame(8'h50, N8);
    add_idle(N8 + 4);
    build_exp8();
    run8();
    for (int c = 0; c < sch_len; c++) begin
      checks++;
      if (obs_en[c] !== exp_en[c] || obs_drop[c] !== exp_drop[c]) begin
        errors++;
        $display("FAIL partial_ctrl c=%0d: en=%b drop=%b, required en=%b drop=%b",
                 c, obs_en[c], obs_drop[c], exp_en[c], exp_drop[c]);
      end
      if (exp_en[c]) begin
        checks++;
        if (obs_re[c] !== exp_re[c] || obs_im[c] !== exp_im[c]) begin
          errors++;
          $display("FAIL partial_data c=%0d: re=%h im=%h, required re=%h im=%h",
                   c, obs_re[c], obs_im[c], exp_re[c], exp_im[c]);
        end
      end
      if (obs_drop[c] === 1'b1) drops++;
    end
    checks++;
    if (drops != 1 || obs_drop[5] !== 1'b1) begin
      errors++;
      $display("FAIL partial_drop: pulses=%0d at5=%b, required 1 pulse at cycle 5", drops, obs_drop[5]);
    end
  endtask

  task automatic test_gaps();
    clear_sched();
    add_idle(2);
    add_frame(8'h00, N8);
    add_idle(2);
    add_frame(8'h08, N8);
    add_frame(8'h10, N8);
    add_idle(11);
    add_frame(8'h18, N8);
    add_idle(N8 + 4);
    build_exp8();
    run8();
    for (int c = 0; c < sch_len; c++) begin
      checks++;
      if (obs_en[c] !== exp_en[c] || obs_drop[c] !== exp_drop[c]) begin
        errors++;
        $display("FAIL gaps_ctrl c=%0d: en=%b drop=%b, required en=%b drop=%b",
                 c, obs_en[c], obs_drop[c], exp_en[c], exp_drop[c]);
      end
      if (exp_en[c]) begin
        checks++;
        if (obs_re[c] !== exp_re[c] || obs_im[c] !== exp_im[c]) begin
          errors++;
          $display("FAIL gaps_data c=%0d: re=%h im=%h, required re=%h im=%h",
                   c, obs_re[c], obs_im[c], exp_re[c], exp_im[c]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    clear_sched();
    add_frame(8'h10, N8);
    add_idle(N8);
    for (int c = 0; c <= 12; c++) begin
      @(negedge clk);
      bus8.enable_in = sch_en[c];
      bus8.in_re     = sch_re[c];
      bus8.in_im     = sch_im[c];
      @(posedge clk);
      #1;
    end
    checks++;
    if (bus8.enable_out !== 1'b1 || bus8.out_re !== 8'h13) begin
      errors++;
      $display("FAIL rst_mid_pre: en=%b re=%h, required en=1 re=13", bus8.enable_out, bus8.out_re);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus8.enable_out, bus8.frame_drop, bus8.out_re, bus8.out_im} !== '0) begin
      errors++;
      $display("FAIL rst_mid_async: en=%b drop=%b re=%h im=%h, required all 0",
               bus8.enable_out, bus8.frame_drop, bus8.out_re, bus8.out_im);
    end
    @(negedge clk);
    bus8.enable_in = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_sched();
    add_frame(8'h20, N8);
    add_idle(N8 + 4);
    build_exp8();
    run8();
    for (int c = 0; c < sch_len; c++) begin
      checks++;
      if (obs_en[c] !== exp_en[c] || obs_drop[c] !== exp_drop[c]) begin
        errors++;
        $display("FAIL rst_mid_ctrl c=%0d: en=%b drop=%b, required en=%b drop=%b",
                 c, obs_en[c], obs_drop[c], exp_en[c], exp_drop[c]);
      end
      if (exp_en[c]) begin
        checks++;
        if (obs_re[c] !== exp_re[c] || obs_im[c] !== exp_im[c]) begin
          errors++;
          $display("FAIL rst_mid_data c=%0d: re=%h im=%h, required re=%h im=%h",
                   c, obs_re[c], obs_im[c], exp_re[c], exp_im[c]);
        end
      end
    end
  endtask

  task automatic test_random_n64();
    localparam int FRAMES = 10;
    localparam int TOTAL = FRAMES * N64;
    logic [2*W64-1:0] din [TOTAL];
    logic [2*W64-1:0] exp_q [$];
    logic [2*W64-1:0] got, want;
    int high = 0, first = -1, last = -1, drops = 0;
    for (int i = 0; i < TOTAL; i++) din[i] = (2*W64)'($urandom);
    for (int f = 0; f < FRAMES; f++)
      for (int j = 0; j < N64; j++) exp_q.push_back(din[f * N64 + rev_bits(j, 6)]);
    for (int c = 0; c < TOTAL + N64 + 8; c++) begin
      @(negedge clk);
      bus64.enable_in = (c < TOTAL);
      {bus64.in_re, bus64.in_im} = (c < TOTAL) ? din[c] : '0;
      @(posedge clk);
      #1;
      if (bus64.frame_drop === 1'b1) drops++;
      if (bus64.enable_out === 1'b1) begin
        high++;
        if (first < 0) first = c;
        last = c;
        got = {bus64.out_re, bus64.out_im};
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL rand64_data c=%0d: got %h, required %h", c, got, want);
        end
      end
    end
    bus64.enable_in = 1'b0;
    checks++;
    if (first != N64 + 1 || high != TOTAL || last != N64 + TOTAL) begin
      errors++;
      $display("FAIL rand64_duty: first=%0d high=%0d last=%0d, required %0d %0d %0d",
               first, high, last, N64 + 1, TOTAL, N64 + TOTAL);
    end
    checks++;
    if (exp_q.size() != 0 || drops != 0) begin
      errors++;
      $display("FAIL rand64_tail: leftover=%0d drops=%0d, required 0 and 0", exp_q.size(), drops);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_partial();
    test_gaps();
    test_reset_mid_frame();
    test_random_n64();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
